// File: rtl/fifo_rd_stream_pkg.sv
// ============================================================================
// Module      : fifo_rd_stream_pkg
// Description : Shared constants and types for the fifo_rd_stream adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_stream_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
    localparam int STATS_W    = 16;

    typedef logic [OCC_W-1:0]   occ_t;
    typedef logic [STATS_W-1:0] stat_t;

endpackage : fifo_rd_stream_pkg

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side adapter for fifo_syn; turns the rd/q handshake into
//               a valid/ready stream through a two-word skid buffer.
//               Optional counters enabled by macro FIFO_RD_STREAM_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occ
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STATS_W-1:0] xfer_cnt,
    output logic [STATS_W-1:0] stall_cnt
`endif
);

    occ_t             r_occ;
    logic             r_pend;
    logic [WIDTH-1:0] r_b0;
    logic [WIDTH-1:0] r_b1;

    logic             w_valid;
    logic             w_pop;
    logic [OCC_W:0]   w_committed;
    occ_t             w_occ_eff;
    occ_t             w_occ_nxt;

    assign w_valid     = (r_occ != '0);
    assign w_pop       = w_valid & out_ready;
    assign w_committed = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_pend};
    assign w_occ_eff   = r_occ - {{(OCC_W-1){1'b0}}, w_pop};
    assign w_occ_nxt   = w_occ_eff + {{(OCC_W-1){1'b0}}, r_pend};

    // Counting the in-flight word keeps the buffer from ever overflowing; the
    // pop term lets a slot freed this cycle be refilled for full throughput.
    assign fifo_rd = ~rst & ~fifo_empty
                   & ((w_committed < (OCC_W+1)'(SKID_DEPTH)) | w_pop);

    assign out_valid = w_valid;
    assign out_data  = r_b0;
    assign occ       = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_pend <= 1'b0;
            r_b0   <= '0;
            r_b1   <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_pend <= fifo_rd;
            if (w_pop) begin
                r_b0 <= r_b1;
            end
            // Arrival lands behind whatever remains after this cycle's pop.
            if (r_pend) begin
                if (w_occ_eff == '0) begin
                    r_b0 <= fifo_q;
                end else begin
                    r_b1 <= fifo_q;
                end
            end
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    stat_t r_xfer_cnt;
    stat_t r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            if (w_valid & ~out_ready) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign xfer_cnt  = r_xfer_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule : fifo_rd_stream

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_rd;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occ;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0]      xfer_cnt;
    logic [15:0]      stall_cnt;
`endif

    fifo_rd_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .occ        (occ)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .xfer_cnt   (xfer_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment: contents of the upstream FIFO.
    logic [WIDTH-1:0] fq[$];
    // Reference model: words delivered to the adapter and not yet consumed,
    // plus the word read last cycle that is still on its way.
    logic [WIDTH-1:0] held[$];
    bit               pend_m;
    logic [WIDTH-1:0] pend_word;
    logic [15:0]      xfer_m;
    logic [15:0]      stall_m;
    int               rd_seen;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        held.delete();
        fq.delete();
        pend_m  = 1'b0;
        xfer_m  = '0;
        stall_m = '0;
    endtask

    // One clock cycle: drive at negedge, check, then let the edge happen.
    task automatic step(input bit rdy);
        bit               pop;
        bit               exp_rd;
        bit               did_rd;
        logic [WIDTH-1:0] word;
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        #1;
        pop    = (held.size() != 0) && rdy;
        exp_rd = (fq.size() != 0) && (((held.size() + int'(pend_m)) < 2) || pop);
        check_eq("out_valid", 32'(out_valid), 32'(held.size() != 0));
        check_eq("occ",       32'(occ),       32'(held.size()));
        check_eq("fifo_rd",   32'(fifo_rd),   32'(exp_rd));
        if (held.size() != 0) check_eq("out_data", 32'(out_data), 32'(held[0]));
`ifdef FIFO_RD_STREAM_STATS_EN
        check_eq("xfer_cnt",  32'(xfer_cnt),  32'(xfer_m));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        if (pop) xfer_m = xfer_m + 16'd1;
        if ((held.size() != 0) && !rdy) stall_m = stall_m + 16'd1;
`endif
        did_rd = fifo_rd && (fq.size() != 0);
        word   = '0;
        if (did_rd) begin
            word = fq.pop_front();
            rd_seen++;
        end
        if (pop) void'(held.pop_front());
        if (pend_m) held.push_back(pend_word);
        pend_m    = did_rd;
        pend_word = word;
        @(posedge clk);
        #1;
        fifo_q = did_rd ? word : WIDTH'($urandom);
        @(negedge clk);
    endtask

    task automatic push_words(input logic [63:0] words, input int n);
        logic [63:0] w;
        w = words;
        for (int i = n - 1; i >= 0; i--) fq.push_back(w[i*8 +: 8]);
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_q     = '0;
        rd_seen    = 0;
        model_clear();
        @(negedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_occ",   32'(occ),       32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_rd",    32'(fifo_rd),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with an always-ready sink.
        push_words(64'hab12_3456_78cd_ccdd, 8);
        rd_seen = 0;
        for (int i = 0; i < 12; i++) step(1'b1);
        check_eq("stream_reads", 32'(rd_seen), 32'd8);

        // Backpressure: fill the skid buffer, then drain.
        push_words(64'h0000_0000_00ab_1234, 3);
        for (int i = 0; i < 4; i++) step(1'b0);
        check_eq("bp_occ", 32'(occ), 32'd2);
        for (int i = 0; i < 5; i++) step(1'b1);

        // Single word then empty.
        push_words(64'h0000_0000_0000_00ee, 1);
        rd_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1);
        check_eq("empty_reads", 32'(rd_seen), 32'd1);

        // Pop and arrival together with the buffer full.
        push_words(64'h0000_0000_0033_4455, 3);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0 && fq.size() < 16) fq.push_back(WIDTH'($urandom));
            step($urandom_range(0, 2) != 0);
        end

        // Reset with data buffered and a read in flight.
        push_words(64'h0000_0000_0011_2233, 3);
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_rd",    32'(fifo_rd),   32'd0);
        check_eq("mid_rst_occ",   32'(occ),       32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1);
        push_words(64'h0000_0000_0000_5a5b, 2);
        for (int i = 0; i < 5; i++) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_rd_stream

`default_nettype wire
